present_sbox_layer: RTL and testbench

Parametrised, multi-cycle PRESENT substitution layer for the PRESENT cipher datapath. Applies either the forward S-box (encrypt) or the inverse S-box (decrypt), selected per block, to every nibble of a STATE_W-bit state, processing LANES nibbles per clock. Sits between the round-key XOR and the permutation layer. Valid/ready handshakes on both sides let the round controller trade area against cycles.

---
 rtl/present_pkg.sv | 28 ++
 rtl/present_sbox_lane.sv | 16 +
 rtl/present_sbox_layer.sv | 125 ++++++++++++
 tb/tb_present_sbox_layer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT cipher definitions: S-box tables and the substitution-layer
// state encoding. Also used by the inverse-S-box table and the cipher datapath.
package present_pkg;

    // Forward PRESENT S-box, indexed by input nibble 0..F
    localparam logic [3:0] PRESENT_SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    // Inverse PRESENT S-box, indexed by input nibble 0..F
    localparam logic [3:0] PRESENT_INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } layer_state_e;

    // Single-nibble substitution in either direction
    function automatic logic [3:0] sbox_lookup(input logic [3:0] nib, input logic inv);
        return inv ? PRESENT_INV_SBOX[nib] : PRESENT_SBOX[nib];
    endfunction

endpackage

// File: rtl/present_sbox_lane.sv
// One combinational substitution lane: a nibble through the forward or
// inverse PRESENT S-box.
module present_sbox_lane
    import present_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       inv,
    output logic [3:0] result
);

    // Table lookup selected by direction
    always_comb begin
        result = sbox_lookup(nibble, inv);
    end

endmodule

// File: rtl/present_sbox_layer.sv
// Multi-cycle PRESENT substitution layer. A block is latched on accept, then
// LANES nibbles per cycle are substituted in place until the whole state is
// done; the result is held in DONE until the consumer takes it.
module present_sbox_layer
    import present_pkg::*;
#(
    parameter int unsigned STATE_W = 64,
    parameter int unsigned LANES   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    localparam int unsigned NIB       = STATE_W / 4;
    localparam int unsigned STEPS     = NIB / LANES;
    localparam int unsigned IDX_W     = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned LANE_BITS = 4 * LANES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

    generate
        if ((STATE_W == 0) || ((STATE_W % 4) != 0)) begin : g_bad_state_w
            $error("present_sbox_layer: STATE_W must be a non-zero multiple of 4");
        end
        if ((LANES == 0) || ((NIB % LANES) != 0)) begin : g_bad_lanes
            $error("present_sbox_layer: LANES must divide STATE_W/4");
        end
    endgenerate

    layer_state_e           state;
    logic [STATE_W-1:0]     data_q;
    logic [STATE_W-1:0]     data_next;
    logic                   mode_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   valid_q;
    logic                   busy_q;
    logic [31:0]            base;
    logic [LANE_BITS-1:0]   window;
    logic [LANE_BITS-1:0]   window_sub;
    logic                   accept;
    logic                   last_step;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_step = (idx_q == LAST_IDX);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = busy_q;

    // Select the group of nibbles handled in the current step
    always_comb begin
        base   = 32'(idx_q) * 32'(LANE_BITS);
        window = data_q[base +: LANE_BITS];
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        present_sbox_lane u_lane (
            .nibble (window[4*j +: 4]),
            .inv    (mode_q),
            .result (window_sub[4*j +: 4])
        );
    end

    // Write the substituted group back into its place in the state
    always_comb begin
        data_next = data_q;
        data_next[base +: LANE_BITS] = window_sub;
    end

    // Control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                end
                ST_RUN: begin
                    data_q <= data_next;
                    if (last_step) begin
                        idx_q   <= '0;
                        state   <= ST_DONE;
                        valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
            // Accept from IDLE or from DONE overrides the case assignments above
            if (accept) begin
                data_q  <= in_data;
                mode_q  <= in_inv;
                idx_q   <= '0;
                state   <= ST_RUN;
                valid_q <= 1'b0;
                busy_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_present_sbox_layer.sv
// Directed and streaming checks for present_sbox_layer, including a lane-count
// sweep on extra instances that share the input side.
module tb_present_sbox_layer;

    localparam logic [3:0] FWD [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };
    localparam logic [3:0] INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_inv = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;

    logic        ready [4];
    logic        valid [4];
    logic        busy  [4];
    logic [63:0] odata [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    present_sbox_layer #(.STATE_W(64), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready[0]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(valid[0]),
        .out_ready(out_ready), .out_data(odata[0]), .busy(busy[0])
    );
    present_sbox_layer #(.STATE_W(64), .LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready[1]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(valid[1]),
        .out_ready(out_ready), .out_data(odata[1]), .busy(busy[1])
    );
    present_sbox_layer #(.STATE_W(64), .LANES(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready[2]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(valid[2]),
        .out_ready(out_ready), .out_data(odata[2]), .busy(busy[2])
    );
    present_sbox_layer #(.STATE_W(64), .LANES(16)) dut_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready[3]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(valid[3]),
        .out_ready(out_ready), .out_data(odata[3]), .busy(busy[3])
    );

    typedef struct {
        logic [63:0] d;
        logic        inv;
        logic [63:0] exp;
    } vec_t;

    function automatic logic [63:0] model(input logic [63:0] x, input logic inv);
        logic [63:0] r;
        logic [3:0]  n;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            n = x[4*k +: 4];
            r[4*k +: 4] = inv ? INV[n] : FWD[n];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one block into the main instance, wait for it, check latency/data, drain it
    task automatic run_block(input logic [63:0] d, input logic inv, input logic [63:0] exp,
                             input string name);
        int n;
        int busy_bad;
        in_data = d; in_inv = inv; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check({name, " in_ready"}, 64'(ready[0]), 64'd1);
        step();
        in_valid = 1'b0;
        n = 1;
        busy_bad = 0;
        while (!valid[0] && n < 40) begin
            if (!busy[0]) busy_bad++;
            step();
            n++;
        end
        check({name, " latency"}, 64'(n), 64'd5);
        check({name, " data"}, odata[0], exp);
        check({name, " busy"}, 64'(busy_bad + (busy[0] ? 0 : 1)), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, " drained"}, 64'(valid[0]), 64'd0);
    endtask

    // Accept a block, advance extra cycles, pulse reset, confirm nothing survives
    task automatic reset_during(input int extra, input string name);
        int leaks;
        in_data = 64'h0123456789ABCDEF; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < extra; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check({name, " out_valid"}, 64'(valid[0]), 64'd0);
        check({name, " in_ready"}, 64'(ready[0]), 64'd1);
        check({name, " busy"}, 64'(busy[0]), 64'd0);
        check({name, " out_data"}, odata[0], 64'd0);
        out_ready = 1'b1;
        leaks = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid[0]) leaks++;
            step();
        end
        out_ready = 1'b0;
        check({name, " stale"}, 64'(leaks), 64'd0);
    endtask

    initial begin
        vec_t        vecs [6];
        int          exp_lat [4];
        int          lat [4];
        logic [63:0] cap [4];
        logic [63:0] held;
        logic [63:0] pat;
        logic [63:0] pexp;
        logic [3:0]  p4;
        logic [3:0]  s4;
        int          n;
        int          bad;
        logic [63:0] sq [$];
        int          sent;
        int          recv;
        int          cyc;
        logic        took;

        vecs[0] = '{64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712};
        vecs[1] = '{64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF};
        vecs[2] = '{64'h0000000000000000, 1'b0, 64'hCCCCCCCCCCCCCCCC};
        vecs[3] = '{64'h0000000000000000, 1'b1, 64'h5555555555555555};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h2222222222222222};
        vecs[5] = '{64'hFEDCBA9876543210, 1'b1, 64'hA970364BD21C8FE5};
        exp_lat = '{5, 17, 9, 2};

        // reset state
        step(); step(); step();
        check("reset in_ready", 64'(ready[0]), 64'd1);
        check("reset out_valid", 64'(valid[0]), 64'd0);
        check("reset busy", 64'(busy[0]), 64'd0);
        check("reset out_data", odata[0], 64'd0);
        rst_n = 1'b1;
        step();

        // table vectors
        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].d, vecs[i].inv, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // drain all instances before the lane sweep
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        out_ready = 1'b0;

        // lane sweep: replicated single-nibble patterns, both modes, all instances
        for (int p = 0; p < 16; p++) begin
            for (int m = 0; m < 2; m++) begin
                p4 = 4'(p);
                s4 = (m != 0) ? INV[p4] : FWD[p4];
                pat = {16{p4}};
                pexp = {16{s4}};
                in_data = pat; in_inv = (m != 0); in_valid = 1'b1; out_ready = 1'b0;
                step();
                in_valid = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    lat[k] = 0;
                    cap[k] = '0;
                end
                for (int c = 1; c <= 20; c++) begin
                    for (int k = 0; k < 4; k++) begin
                        if (lat[k] == 0 && valid[k]) begin
                            lat[k] = c;
                            cap[k] = odata[k];
                        end
                    end
                    step();
                end
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("sweep i%0d p%0h m%0d latency", k, p, m), 64'(lat[k]), 64'(exp_lat[k]));
                    check($sformatf("sweep i%0d p%0h m%0d data", k, p, m), cap[k], pexp);
                end
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
            end
        end

        // backpressure: hold result for 10 cycles, then accept in the release cycle
        in_data = 64'h0123456789ABCDEF; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!valid[0] && n < 40) begin step(); n++; end
        check("bp latency", 64'(n), 64'd5);
        held = odata[0];
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!valid[0] || odata[0] !== held || ready[0]) bad++;
            step();
        end
        check("bp held data", held, 64'hC56B90AD3EF84712);
        check("bp stable", 64'(bad), 64'd0);
        in_data = 64'hC56B90AD3EF84712; in_inv = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp in_ready comb", 64'(ready[0]), 64'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp reaccept busy", 64'(busy[0]), 64'd1);
        check("bp reaccept out_valid", 64'(valid[0]), 64'd0);
        n = 1;
        while (!valid[0] && n < 40) begin step(); n++; end
        check("bp second latency", 64'(n), 64'd5);
        check("bp second data", odata[0], 64'h0123456789ABCDEF);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // mid-block disturbance on data and mode
        in_data = 64'h13579BDF02468ACE; in_inv = 1'b0; in_valid = 1'b1;
        step();
        n = 1;
        while (!valid[0] && n < 40) begin
            in_data = {$urandom, $urandom};
            in_inv = ~in_inv;
            step();
            n++;
        end
        in_valid = 1'b0;
        check("disturb latency", 64'(n), 64'd5);
        check("disturb data", odata[0], model(64'h13579BDF02468ACE, 1'b0));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // reset during RUN and during DONE
        reset_during(2, "rst run");
        reset_during(6, "rst done");

        // random streaming against the reference model
        sent = 0; recv = 0; cyc = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        while (recv < 1000 && cyc < 40000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_data = {$urandom, $urandom};
                in_inv = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            took = in_valid && ready[0];
            if (took) begin
                sq.push_back(model(in_data, in_inv));
                sent++;
            end
            if (valid[0] && out_ready) begin
                if (sq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stream duplicate: got %h expected none", odata[0]);
                end else begin
                    check($sformatf("stream blk%0d", recv), odata[0], sq.pop_front());
                end
                recv++;
            end
            step();
            cyc++;
            if (took) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("stream received", 64'(recv), 64'd1000);
        check("stream sent", 64'(sent), 64'd1000);
        check("stream leftover", 64'(sq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
